// File: rtl/cpu_cycle_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
package cpu_cycle_ctrl_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned IRQ_LEVEL_W = 3;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned CNT_W_DEF   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_INTR  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_cycle_ctrl_if.sv
// Bus handshake and interrupt lines between the sequencer and the memory/IRQ side.
interface cpu_cycle_ctrl_if;
    import cpu_cycle_ctrl_pkg::*;

    logic                   ACKI_n;
    logic                   ACKD_n;
    logic [IRQ_LEVEL_W-1:0] OINT_n;
    logic                   imem_req;
    logic                   mreq;
    logic                   write;
    logic                   IACK_n;
    logic [IRQ_LEVEL_W-1:0] int_level;

    modport master (
        input  ACKI_n, ACKD_n, OINT_n,
        output imem_req, mreq, write, IACK_n, int_level
    );

    modport slave (
        output ACKI_n, ACKD_n, OINT_n,
        input  imem_req, mreq, write, IACK_n, int_level
    );
endinterface

// File: rtl/cpu_cycle_ctrl_wait_timer.sv
// Ack wait counter; expired_c flags the last cycle an ack may still arrive.
module cpu_cycle_ctrl_wait_timer #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // One more idle cycle would bring the count to TIMEOUT.
    assign expired_c = (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/cpu_cycle_ctrl.sv
// Fetch/execute/memory/writeback sequencer with ack timeout and one-deep interrupt nesting.
module cpu_cycle_ctrl
    import cpu_cycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    cpu_cycle_ctrl_if.master    bus,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                reg_write,
    input  logic                irq_ret,
    output logic                ir_we,
    output logic                md_we,
    output logic                rf_wr_n,
    output logic                pc_we,
    output logic                pc_vec_sel,
    output logic                bus_err,
    output logic [STATE_W-1:0]  state
);
    state_t                 state_q;
    state_t                 state_next;
    logic [IRQ_LEVEL_W-1:0] mask_q;
    logic [IRQ_LEVEL_W-1:0] saved_mask_q;
    logic [IRQ_LEVEL_W-1:0] level_q;
    logic [IRQ_LEVEL_W-1:0] level;
    logic [IRQ_LEVEL_W-1:0] eff_mask;
    logic                   irq_take;
    logic                   expired_c;
    logic                   imem_req;
    logic                   mreq;
    logic                   write;
    logic                   iack_n;

    cpu_cycle_ctrl_wait_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_next != state_q),
        .en        ((state_q == S_FETCH) || (state_q == S_MEM)),
        .expired_c (expired_c)
    );

    assign level = ~bus.OINT_n;

    // Next-state and per-state control decode.
    always_comb begin
        state_next = state_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        mreq       = 1'b0;
        write      = 1'b0;
        md_we      = 1'b0;
        rf_wr_n    = 1'b1;
        pc_we      = 1'b0;
        pc_vec_sel = 1'b0;
        iack_n     = 1'b1;
        irq_take   = 1'b0;
        eff_mask   = mask_q;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = ~bus.ACKI_n;
                if (!bus.ACKI_n) begin
                    state_next = S_EXEC;
                end else if (expired_c) begin
                    state_next = S_ERR;
                end
            end
            S_EXEC: begin
                state_next = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mreq  = 1'b1;
                write = is_store;
                // Load+store together behaves as a store, so no load data latch.
                md_we = is_load & ~is_store & ~bus.ACKD_n;
                if (!bus.ACKD_n) begin
                    state_next = S_WB;
                end else if (expired_c) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                rf_wr_n = ~(reg_write & ~is_store);
                pc_we   = 1'b1;
                if (irq_ret) begin
                    eff_mask = saved_mask_q;
                end
                if (level > eff_mask) begin
                    irq_take   = 1'b1;
                    state_next = S_INTR;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_INTR: begin
                iack_n     = 1'b0;
                pc_we      = 1'b1;
                pc_vec_sel = 1'b1;
                state_next = S_FETCH;
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    // State, interrupt mask bookkeeping and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            mask_q       <= '0;
            saved_mask_q <= '0;
            level_q      <= '0;
            bus_err      <= 1'b0;
        end else begin
            state_q <= state_next;
            if (state_q == S_WB && irq_ret) begin
                mask_q <= saved_mask_q;
            end
            if (irq_take) begin
                level_q <= level;
            end
            if (state_q == S_INTR) begin
                saved_mask_q <= mask_q;
                mask_q       <= level_q;
            end
            if (state_next == S_ERR) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.mreq      = mreq;
    assign bus.write     = write;
    assign bus.IACK_n    = iack_n;
    assign bus.int_level = (state_q == S_INTR) ? level_q : mask_q;
    assign state         = state_q;
endmodule
